// File: rtl/debug_run_controller.sv
// Debug run controller: halt/continue/step sequencing and PC breakpoints.
// Owns ds_cpu_halt; host talks through a valid/ready port with a response pulse.
module debug_run_controller #(
    parameter int NUM_BP       = 2,
    parameter bit RESET_HALTED = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [1:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    input  logic [31:0] dbg_pc,
    input  logic        stall_lw,
    output logic        ds_cpu_halt
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_HALTED = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;

    localparam logic [2:0] OP_HALT   = 3'd0;
    localparam logic [2:0] OP_CONT   = 3'd1;
    localparam logic [2:0] OP_STEP   = 3'd2;
    localparam logic [2:0] OP_RDPC   = 3'd3;
    localparam logic [2:0] OP_SETBP  = 3'd4;
    localparam logic [2:0] OP_CLRBP  = 3'd5;
    localparam logic [2:0] OP_STATUS = 3'd6;

    localparam logic [1:0] RST_STATE = RESET_HALTED ? ST_HALTED : ST_RUN;

    logic [1:0]        state;
    logic [31:0]       bp_addr [NUM_BP];
    logic [NUM_BP-1:0] bp_en;
    logic              skip;
    logic              bp_hit;
    logic [1:0]        hit_idx;
    logic              step_pend;

    logic              match;
    logic [1:0]        match_idx;
    logic              bp_stop;
    logic              retire;
    logic              accept;
    logic              idx_ok;
    logic              rsp_now;
    logic [31:0]       rsp_next;
    logic [31:0]       status;

    // Descending scan leaves the lowest matching index in match_idx.
    always_comb begin
        match     = 1'b0;
        match_idx = 2'd0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en[i] && ((bp_addr[i] ^ dbg_pc) & 32'hFFFF_FFFC) == 32'h0) begin
                match     = 1'b1;
                match_idx = 2'(i);
            end
        end
    end

    assign bp_stop     = (state == ST_RUN) & match & ~skip;
    assign ds_cpu_halt = (state == ST_HALTED) | bp_stop;
    assign retire      = ~ds_cpu_halt & ~stall_lw;

    // step_pend blocks new commands so a step response never collides.
    assign cmd_ready = ~(state == ST_STEP)
                     & ~((state == ST_RUN) & stall_lw)
                     & ~step_pend;
    assign accept    = cmd_valid & cmd_ready;
    assign idx_ok    = {1'b0, cmd_idx} < 3'(NUM_BP);

    assign status = {24'h0, hit_idx, 2'b00, skip, bp_hit,
                     state == ST_STEP, state == ST_HALTED};

    always_comb begin
        rsp_now  = accept;
        rsp_next = 32'h0;
        case (cmd_op)
            OP_HALT:   rsp_next = dbg_pc;
            OP_CONT:   rsp_next = 32'h0;
            OP_STEP: begin
                rsp_now  = accept & (state != ST_HALTED);
                rsp_next = 32'hFFFF_FFFF;
            end
            OP_RDPC:   rsp_next = dbg_pc;
            OP_SETBP,
            OP_CLRBP:  rsp_next = idx_ok ? 32'h0 : 32'hFFFF_FFFF;
            OP_STATUS: rsp_next = status;
            default:   rsp_next = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RST_STATE;
            bp_en     <= '0;
            for (int i = 0; i < NUM_BP; i++) bp_addr[i] <= 32'h0;
            skip      <= 1'b0;
            bp_hit    <= 1'b0;
            hit_idx   <= 2'd0;
            step_pend <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            step_pend <= 1'b0;
            if (retire) skip <= 1'b0;
            if (state == ST_STEP && retire) begin
                state     <= ST_HALTED;
                step_pend <= 1'b1;
            end
            // PC is sampled one cycle after the step retires.
            if (step_pend) begin
                rsp_valid <= 1'b1;
                rsp_data  <= dbg_pc;
            end
            if (accept) begin
                if (rsp_now) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= rsp_next;
                end
                case (cmd_op)
                    OP_HALT: state <= ST_HALTED;
                    OP_CONT: begin
                        bp_hit <= 1'b0;
                        if (state == ST_HALTED) begin
                            state <= ST_RUN;
                            skip  <= 1'b1;
                        end
                    end
                    OP_STEP: begin
                        bp_hit <= 1'b0;
                        if (state == ST_HALTED) state <= ST_STEP;
                    end
                    OP_SETBP: begin
                        for (int i = 0; i < NUM_BP; i++) begin
                            if (cmd_idx == 2'(i)) begin
                                bp_addr[i] <= cmd_arg;
                                bp_en[i]   <= 1'b1;
                            end
                        end
                    end
                    OP_CLRBP: begin
                        for (int i = 0; i < NUM_BP; i++) begin
                            if (cmd_idx == 2'(i)) begin
                                bp_addr[i] <= 32'h0;
                                bp_en[i]   <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            // A breakpoint hit overrides whatever the command did to state.
            if (bp_stop) begin
                state   <= ST_HALTED;
                bp_hit  <= 1'b1;
                hit_idx <= match_idx;
            end
        end
    end

endmodule
